// File: rtl/pll_reset_seq_if.sv
// Bundles the PLL lock/restart inputs and the sequencer status outputs.
// The slave modport is the sequencer side; master is the side that watches it.
interface pll_reset_seq_if;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;

    modport master (
        output pll_lock,
        output restart,
        input  pll_reset,
        input  sys_rst_n,
        input  locked,
        input  fault,
        input  retry_cnt
    );

    modport slave (
        input  pll_lock,
        input  restart,
        output pll_reset,
        output sys_rst_n,
        output locked,
        output fault,
        output retry_cnt
    );
endinterface

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer running on the PLL reference clock.
// Pulses the PLL reset, waits for a qualified lock (with timeout and bounded
// retries), then releases the active-low system reset. Lock loss restarts the PLL.
module pll_reset_seq #(
    parameter int RST_PULSE_CYC    = 270,
    parameter int LOCK_TIMEOUT_CYC = 27000,
    parameter int LOCK_STABLE_CYC  = 2700,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 16
) (
    input  logic              clkin,
    input  logic              rst_n,
    pll_reset_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_RESET_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
    localparam logic [CNT_W-1:0] L_RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] L_STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       L_MAX_RETRY = 4'(MAX_RETRIES);

    logic             r_lock_meta;
    logic             r_lock_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_nxt;

    logic             r_pll_reset;
    logic             r_sys_rst_n;
    logic             r_locked;
    logic             r_fault;
    logic             w_pll_reset_nxt;
    logic             w_sys_rst_n_nxt;
    logic             w_locked_nxt;
    logic             w_fault_nxt;

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // State register with the shared cycle counter and retry count.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET_PLL;
            r_cnt   <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state logic: restart first, then lock beats timeout in WAIT_LOCK.
    always_comb begin
        // NOTE: defaults before any branch keep this purely combinational (no latches).
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;

        if (bus.restart) begin
            w_state_nxt = ST_RESET_PLL;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == L_RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == L_TO_LAST) begin
                        if (r_retry == L_MAX_RETRY) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_state_nxt = ST_RESET_PLL;
                            w_retry_nxt = r_retry + 4'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    // Any drop restarts the stability window without charging a retry.
                    if (!r_lock_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_cnt == L_STB_LAST) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Lock loss starts a fresh sequence, so the retry budget is refilled.
                    if (!r_lock_s) begin
                        w_state_nxt = ST_RESET_PLL;
                        w_retry_nxt = '0;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_RESET_PLL;
                    w_retry_nxt = '0;
                end
            endcase
        end

        // Counter clears on every state entry (and on restart, even from RESET_PLL).
        if (bus.restart || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + L_CNT_ONE;
        end
    end

    // Output decode from the next state so registered outputs track the state flop.
    always_comb begin
        w_pll_reset_nxt = 1'b0;
        w_sys_rst_n_nxt = 1'b0;
        w_locked_nxt    = 1'b0;
        w_fault_nxt     = 1'b0;
        case (w_state_nxt)
            ST_RESET_PLL: w_pll_reset_nxt = 1'b1;
            ST_RUN: begin
                w_sys_rst_n_nxt = 1'b1;
                w_locked_nxt    = 1'b1;
            end
            ST_FAULT: begin
                w_pll_reset_nxt = 1'b1;
                w_fault_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    // Output flops; async reset drops sys_rst_n and raises pll_reset without a clock.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_reset <= w_pll_reset_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_locked    <= w_locked_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign bus.pll_reset = r_pll_reset;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.locked    = r_locked;
    assign bus.fault     = r_fault;
    assign bus.retry_cnt = r_retry;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with small timing parameters.
// Expected output snapshots are queued with the cycle they are due and
// compared on the falling edge when that cycle arrives.
module tb_pll_reset_seq;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_STB = 8;
    localparam int P_MAX = 2;

    typedef struct {
        int         due;
        string      tag;
        logic [7:0] exp;
    } sb_t;

    logic    clkin = 1'b0;
    logic    rst_n;
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_err = 0;
    sb_t     sb[$];
    sb_t     sb_e;
    int      c;
    logic [7:0] w_obs;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .RST_PULSE_CYC    (P_RST),
        .LOCK_TIMEOUT_CYC (P_TO),
        .LOCK_STABLE_CYC  (P_STB),
        .MAX_RETRIES      (P_MAX),
        .CNT_W            (16)
    ) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Rising-edge count; stable when sampled on the falling edge.
    always @(posedge clkin) cyc <= cyc + 1;

    // Observed snapshot: {pll_reset, sys_rst_n, locked, fault, retry_cnt}.
    assign w_obs = {bus.pll_reset, bus.sys_rst_n, bus.locked, bus.fault, bus.retry_cnt};

    function automatic logic [7:0] s_rst(input logic [3:0] r);   return {4'b1000, r}; endfunction
    function automatic logic [7:0] s_wait(input logic [3:0] r);  return {4'b0000, r}; endfunction
    function automatic logic [7:0] s_run(input logic [3:0] r);   return {4'b0110, r}; endfunction
    function automatic logic [7:0] s_fault(input logic [3:0] r); return {4'b1001, r}; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int due, input string tag, input logic [7:0] v);
        sb_t e;
        e.due = due;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clkin);
    endtask

    // Scoreboard consumer: compare every entry whose cycle has arrived.
    always @(negedge clkin) begin
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            sb_e = sb.pop_front();
            if (sb_e.due != cyc) check({sb_e.tag, "_late"}, cyc, sb_e.due);
            else                 check(sb_e.tag, {24'd0, w_obs}, {24'd0, sb_e.exp});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b0;
        repeat (3) @(negedge clkin);
        check("reset_state", {24'd0, w_obs}, {24'd0, s_rst(4'd0)});

        // 1: release reset, lock 6 cycles later, RUN 8 cycles after STABLE entry.
        c = cyc;
        rst_n = 1'b1;
        push_exp(c + 1,  "t1_pulse_first", s_rst(4'd0));
        push_exp(c + 3,  "t1_pulse_last",  s_rst(4'd0));
        push_exp(c + 4,  "t1_wait_lock",   s_wait(4'd0));
        push_exp(c + 16, "t1_stable_hold", s_wait(4'd0));
        push_exp(c + 17, "t1_run",         s_run(4'd0));
        push_exp(c + 30, "t1_run_hold",    s_run(4'd0));
        wait_until(c + 6);
        bus.pll_lock = 1'b1;
        wait_until(c + 30);

        // 4: lock loss in RUN -> RESET_PLL 3 edges later, then a normal relock.
        c = cyc;
        bus.pll_lock = 1'b0;
        push_exp(c + 2,  "t4_run_before",  s_run(4'd0));
        push_exp(c + 3,  "t4_lost",        s_rst(4'd0));
        push_exp(c + 6,  "t4_pulse_last",  s_rst(4'd0));
        push_exp(c + 7,  "t4_wait_lock",   s_wait(4'd0));
        push_exp(c + 17, "t4_stable_hold", s_wait(4'd0));
        push_exp(c + 18, "t4_run",         s_run(4'd0));
        wait_until(c + 7);
        bus.pll_lock = 1'b1;
        wait_until(c + 20);

        // 3: one-cycle lock_s drop at STABLE counter 5 restarts the window.
        c = cyc;
        bus.restart = 1'b1;
        push_exp(c + 1,  "t3_restart",     s_rst(4'd0));
        push_exp(c + 5,  "t3_wait_lock",   s_wait(4'd0));
        push_exp(c + 11, "t3_stable_cnt5", s_wait(4'd0));
        push_exp(c + 14, "t3_no_early_run", s_wait(4'd0));
        push_exp(c + 20, "t3_window_full", s_wait(4'd0));
        push_exp(c + 21, "t3_run",         s_run(4'd0));
        wait_until(c + 1);
        bus.restart = 1'b0;
        wait_until(c + 9);
        bus.pll_lock = 1'b0;
        wait_until(c + 10);
        bus.pll_lock = 1'b1;
        wait_until(c + 22);

        // 2: no lock -> three pulses, retries 0,1,2, then sticky FAULT.
        c = cyc;
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b1;
        push_exp(c + 1,   "t2_pulse0",      s_rst(4'd0));
        push_exp(c + 4,   "t2_pulse0_last", s_rst(4'd0));
        push_exp(c + 5,   "t2_wait0",       s_wait(4'd0));
        push_exp(c + 24,  "t2_wait0_last",  s_wait(4'd0));
        push_exp(c + 25,  "t2_pulse1",      s_rst(4'd1));
        push_exp(c + 28,  "t2_pulse1_last", s_rst(4'd1));
        push_exp(c + 29,  "t2_wait1",       s_wait(4'd1));
        push_exp(c + 48,  "t2_wait1_last",  s_wait(4'd1));
        push_exp(c + 49,  "t2_pulse2",      s_rst(4'd2));
        push_exp(c + 53,  "t2_wait2",       s_wait(4'd2));
        push_exp(c + 72,  "t2_wait2_last",  s_wait(4'd2));
        push_exp(c + 73,  "t2_fault",       s_fault(4'd2));
        push_exp(c + 100, "t2_fault_hold",  s_fault(4'd2));
        wait_until(c + 1);
        bus.restart = 1'b0;
        wait_until(c + 100);

        // 5: restart out of FAULT, then relock to RUN.
        c = cyc;
        bus.pll_lock = 1'b1;
        bus.restart  = 1'b1;
        push_exp(c + 1,  "t5_restart",     s_rst(4'd0));
        push_exp(c + 4,  "t5_pulse_last",  s_rst(4'd0));
        push_exp(c + 5,  "t5_wait_lock",   s_wait(4'd0));
        push_exp(c + 13, "t5_stable_hold", s_wait(4'd0));
        push_exp(c + 14, "t5_run",         s_run(4'd0));
        wait_until(c + 1);
        bus.restart = 1'b0;
        wait_until(c + 15);

        // 6: async reset mid-WAIT_LOCK (retry_cnt=1), then a fresh pulse.
        c = cyc;
        bus.pll_lock = 1'b0;
        bus.restart  = 1'b1;
        push_exp(c + 1,  "t6_restart", s_rst(4'd0));
        push_exp(c + 29, "t6_wait1",   s_wait(4'd1));
        push_exp(c + 35, "t6_pre_rst", s_wait(4'd1));
        wait_until(c + 1);
        bus.restart = 1'b0;
        wait_until(c + 35);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {24'd0, w_obs}, {24'd0, s_rst(4'd0)});
        wait_until(c + 38);
        c = cyc;
        rst_n = 1'b1;
        push_exp(c + 1, "t6_pulse_first", s_rst(4'd0));
        push_exp(c + 3, "t6_pulse_last",  s_rst(4'd0));
        push_exp(c + 4, "t6_wait_lock",   s_wait(4'd0));
        wait_until(c + 6);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
